shared_bus_mux: RTL
===================

# shared_bus_mux

Downstream consumer of the round-robin grant vector: latches the granted master as bus owner, routes that master's burst command and write data onto a single shared slave port, and returns read data and a completion pulse to the owner. A small FSM sequences single-outstanding beats, so the arbiter's grant changes never tear a burst in progress.

## Interface
- PORTS, 2, number of masters; must match the arbiter.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- LEN_W, 4, burst length field width; beats = len+1.
- i_clk  in  1  clock.
- i_rstn  in  1  reset: synchronous, active-low; clock i_clk.
- i_grant_vec  in  PORTS  one-hot grant from the arbiter.
- i_m_valid  in  PORTS  per-master command valid.
- i_m_we  in  PORTS  per-master write (1) / read (0).
- i_m_addr  in  PORTS*ADDR_W  packed start addresses; master i at slice [i*ADDR_W +: ADDR_W].
- i_m_len  in  PORTS*LEN_W  packed burst lengths.
- i_m_wdata  in  PORTS*DATA_W  packed write data.
- o_m_wack  out  PORTS  write beat consumed; master advances wdata next cycle.
- o_m_rvalid  out  PORTS  read beat valid for master i.
- o_m_rdata  out  DATA_W  read data (shared; qualified by o_m_rvalid).
- o_m_done  out  PORTS  one-cycle burst completion pulse.
- o_s_valid  out  1  slave beat request.
- o_s_we  out  1  slave write.
- o_s_addr  out  ADDR_W  slave beat address.
- o_s_wdata  out  DATA_W  slave write data.
- i_s_ready  in  1  slave accepts beat.
- i_s_rvalid  in  1  slave read data valid.
- i_s_rdata  in  DATA_W  slave read data.
- o_busy  out  1  burst in progress.
- o_owner_idx  out  $clog2(PORTS)  latched owner index.

## Operation
- States: IDLE, CMD, RESP, DONE.
- IDLE: if i_grant_vec is exactly one-hot and i_m_valid[g] is 1 for granted g: latch owner=g, we, addr, beats_left=len → CMD. Zero or multi-hot grant: stay IDLE, no slave activity.
- CMD: o_s_valid=1, o_s_addr=current addr, o_s_we=latched we, o_s_wdata=owner's i_m_wdata (combinational mux). On i_s_ready:
  - write: o_m_wack[owner]=1 same cycle; addr += DATA_W/8; beats_left==0 → DONE, else stay CMD.
  - read: → RESP.
- RESP: o_s_valid=0; on i_s_rvalid: o_m_rdata<=i_s_rdata, o_m_rvalid[owner]<=1 (registered, one cycle); addr += DATA_W/8; beats_left==0 → DONE, else decrement → CMD.
- Write path also decrements beats_left per accepted beat.
- DONE: o_m_done[owner]=1 for one cycle → IDLE.
- Address increment wraps modulo 2^ADDR_W; no error.
- Grant changes, master valid drops, or i_s_rvalid outside RESP while not IDLE: ignored; burst completes on latched owner.
- i_s_rvalid arriving in the same cycle as i_s_ready: not accepted; slave returns read data ≥1 cycle after accept.

## Timing
- Reset (i_rstn=0 at edge): state=IDLE; o_s_valid, o_s_we, o_m_wack, o_m_rvalid, o_m_done, o_busy all 0; o_s_addr, o_m_rdata, o_owner_idx = 0. Reset mid-burst aborts immediately; no o_m_done.
- Grant+valid sampled at edge N → o_s_valid high in cycle N+1 (1-cycle latency).
- Write burst of B beats with ready always high: B cycles in CMD, +1 DONE; next IDLE sample one cycle after done.
- Read beat: i_s_rvalid at edge M → o_m_rvalid high in cycle M+1.
- o_busy=1 in CMD, RESP, DONE.

## Structure
- Package shared_bus_pkg: state enum typedef (IDLE, CMD, RESP, DONE), BYTES_PER_BEAT = DATA_W/8 helper function.
- Sub-module onehot_to_index: PORTS-wide one-hot → index plus o_onehot (exactly one bit set); reusable by other grant consumers.

## Test plan
- PORTS=2, grant=2'b01, m0 write addr=0x100 len=2, ready=1 → o_s_addr 0x100,0x104,0x108 in consecutive cycles, o_m_wack[0] ×3, o_m_done[0] next cycle.
- grant=2'b10, m1 read addr=0x20 len=1, rvalid 2 cycles after each accept with rdata 0xAA,0xBB → o_m_rvalid[1] twice with 0xAA,0xBB; o_m_done[1].
- Grant flips to 2'b01 mid m1 burst → beats stay with m1; m0 starts only after DONE.
- Addr=0xFFFFFFFC len=1 write → second beat address 0x00000000.
- grant=2'b11 or 2'b00 with valids high → o_s_valid stays 0 for 10 cycles.
- i_rstn low during CMD with ready=0 → next cycle all outputs 0, no o_m_done; new burst starts cleanly after release.

Source files
------------

// File: rtl/shared_bus_pkg.sv
// Shared types and helpers for the shared-bus multiplexer and other grant consumers.
package shared_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int unsigned bytes_per_beat(input int unsigned data_w);
    return data_w / 32'd8;
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// Converts a one-hot vector to its bit index; o_onehot flags exactly one bit set.
module onehot_to_index #(
  parameter  int PORTS = 2,
  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_onehot
);

  // OR of set-bit indices; only meaningful when o_onehot is high
  always_comb begin
    o_idx = {IDX_W{1'b0}};
    for (int i = 0; i < PORTS; i++) begin
      o_idx = o_idx | (i_vec[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
  end

  assign o_onehot = (i_vec != {PORTS{1'b0}}) &&
                    ((i_vec & (i_vec - PORTS'(1))) == {PORTS{1'b0}});

endmodule

// File: rtl/shared_bus_mux.sv
// Latches the granted master as bus owner and sequences its burst, one beat
// outstanding at a time, onto a single shared slave port.
module shared_bus_mux
  import shared_bus_pkg::*;
#(
  parameter  int PORTS  = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LEN_W  = 4,
  localparam int IDX_W  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [PORTS-1:0]      i_grant_vec,
  input  logic [PORTS-1:0]      i_m_valid,
  input  logic [PORTS-1:0]      i_m_we,
  input  logic [PORTS*ADDR_W-1:0] i_m_addr,
  input  logic [PORTS*LEN_W-1:0]  i_m_len,
  input  logic [PORTS*DATA_W-1:0] i_m_wdata,
  output logic [PORTS-1:0]      o_m_wack,
  output logic [PORTS-1:0]      o_m_rvalid,
  output logic [DATA_W-1:0]     o_m_rdata,
  output logic [PORTS-1:0]      o_m_done,
  output logic                  o_s_valid,
  output logic                  o_s_we,
  output logic [ADDR_W-1:0]     o_s_addr,
  output logic [DATA_W-1:0]     o_s_wdata,
  input  logic                  i_s_ready,
  input  logic                  i_s_rvalid,
  input  logic [DATA_W-1:0]     i_s_rdata,
  output logic                  o_busy,
  output logic [IDX_W-1:0]      o_owner_idx
);

  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(bytes_per_beat(DATA_W));

  state_t              r_state, w_nxt_state;
  logic [IDX_W-1:0]    r_owner, w_nxt_owner;
  logic                r_we, w_nxt_we;
  logic [ADDR_W-1:0]   r_addr, w_nxt_addr;
  logic [LEN_W-1:0]    r_beats, w_nxt_beats;
  logic [DATA_W-1:0]   r_rdata, w_nxt_rdata;
  logic [PORTS-1:0]    r_rvalid, w_nxt_rvalid;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_onehot;
  logic [PORTS-1:0]    w_owner_oh;

  onehot_to_index #(.PORTS(PORTS)) u_grant_idx (
    .i_vec    (i_grant_vec),
    .o_idx    (w_grant_idx),
    .o_onehot (w_grant_onehot)
  );

  assign w_owner_oh = PORTS'(1) << r_owner;

  // Next-state and next-datapath; arbiter inputs are only looked at in IDLE
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_owner  = r_owner;
    w_nxt_we     = r_we;
    w_nxt_addr   = r_addr;
    w_nxt_beats  = r_beats;
    w_nxt_rdata  = r_rdata;
    w_nxt_rvalid = {PORTS{1'b0}};
    case (r_state)
      IDLE: begin
        if (w_grant_onehot && i_m_valid[w_grant_idx]) begin
          w_nxt_owner = w_grant_idx;
          w_nxt_we    = i_m_we[w_grant_idx];
          w_nxt_addr  = i_m_addr[w_grant_idx*ADDR_W +: ADDR_W];
          w_nxt_beats = i_m_len[w_grant_idx*LEN_W +: LEN_W];
          w_nxt_state = CMD;
        end else begin
          w_nxt_state = IDLE;
        end
      end
      CMD: begin
        if (i_s_ready) begin
          if (r_we) begin
            w_nxt_addr = r_addr + ADDR_INC;
            if (r_beats == {LEN_W{1'b0}}) begin
              w_nxt_state = DONE;
            end else begin
              w_nxt_beats = r_beats - LEN_W'(1);
              w_nxt_state = CMD;
            end
          end else begin
            w_nxt_state = RESP;
          end
        end else begin
          w_nxt_state = CMD;
        end
      end
      RESP: begin
        if (i_s_rvalid) begin
          w_nxt_rdata  = i_s_rdata;
          w_nxt_rvalid = w_owner_oh;
          w_nxt_addr   = r_addr + ADDR_INC;
          if (r_beats == {LEN_W{1'b0}}) begin
            w_nxt_state = DONE;
          end else begin
            w_nxt_beats = r_beats - LEN_W'(1);
            w_nxt_state = CMD;
          end
        end else begin
          w_nxt_state = RESP;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state  <= IDLE;
      r_owner  <= {IDX_W{1'b0}};
      r_we     <= 1'b0;
      r_addr   <= {ADDR_W{1'b0}};
      r_beats  <= {LEN_W{1'b0}};
      r_rdata  <= {DATA_W{1'b0}};
      r_rvalid <= {PORTS{1'b0}};
    end else begin
      r_state  <= w_nxt_state;
      r_owner  <= w_nxt_owner;
      r_we     <= w_nxt_we;
      r_addr   <= w_nxt_addr;
      r_beats  <= w_nxt_beats;
      r_rdata  <= w_nxt_rdata;
      r_rvalid <= w_nxt_rvalid;
    end
  end

  assign o_s_valid   = (r_state == CMD);
  assign o_s_we      = o_s_valid & r_we;
  assign o_s_addr    = r_addr;
  assign o_s_wdata   = i_m_wdata[r_owner*DATA_W +: DATA_W];
  assign o_m_wack    = (o_s_valid && r_we && i_s_ready) ? w_owner_oh : {PORTS{1'b0}};
  assign o_m_rvalid  = r_rvalid;
  assign o_m_rdata   = r_rdata;
  assign o_m_done    = (r_state == DONE) ? w_owner_oh : {PORTS{1'b0}};
  assign o_busy      = (r_state != IDLE);
  assign o_owner_idx = r_owner;

endmodule
